// File: rtl/data_mem_responder.sv
// data_mem_responder: word-organised data memory behind a single-outstanding
// load/store request/response interface with a programmable access latency.
// Optional access checking is enabled by defining DMEM_ERR_CHECK_EN; without it
// addresses wrap modulo 4*DEPTH and rsp_err is tied low.
module data_mem_responder #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;

    logic [31:0]       mem [DEPTH];

    logic [IDX_W-1:0]  idx;
    logic              accept;
    logic              enter_resp;
    logic              access_err;
    logic              mem_we;

    assign idx        = addr_q[IDX_W+1:2];
    assign req_ready  = rst && (state_q == IDLE);
    assign accept     = req_valid && req_ready;
    // The last WAIT cycle (counter already 0) is the edge that enters RESP.
    assign enter_resp = (state_q == WAIT) && (cnt_q == 4'd0);
    assign mem_we     = enter_resp && we_q && !access_err;

    assign rsp_valid  = (state_q == RESP);
    assign rsp_rdata  = rdata_q;
    assign rsp_err    = err_q;

`ifdef DMEM_ERR_CHECK_EN
    logic out_of_range;
    logic strb_ok;

    // Flag out-of-range addresses and strobe patterns that do not match the byte offset.
    always_comb begin
        out_of_range = (addr_q >= ADDR_W'(4 * DEPTH));
        case ({addr_q[1:0], wstrb_q})
            {2'd0, 4'b0001}, {2'd0, 4'b0011}, {2'd0, 4'b1111},
            {2'd1, 4'b0010},
            {2'd2, 4'b0100}, {2'd2, 4'b1100},
            {2'd3, 4'b1000}: strb_ok = 1'b1;
            default:         strb_ok = 1'b0;
        endcase
        access_err = out_of_range || (we_q ? !strb_ok : (addr_q[1:0] != 2'd0));
    end
`else
    // Upper address bits and byte offset only matter when checking is enabled.
    logic unused_addr;
    assign unused_addr = ^{addr_q[ADDR_W-1:IDX_W+2], addr_q[1:0]};
    assign access_err  = 1'b0;
`endif

    // Next-state logic for the IDLE -> WAIT -> RESP -> IDLE sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = WAIT;
                    cnt_d   = 4'(LATENCY);
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    err_d   = access_err;
                    rdata_d = (we_q || access_err) ? 32'd0 : mem[idx];
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and response registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Capture the request fields on acceptance; held for the whole transaction.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
        end
    end

    // Byte-lane store on the edge entering RESP; a reset on that edge suppresses it.
    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) begin
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule
